// File: rtl/regfile_writeback_arbiter_if.sv
// rtl/regfile_writeback_arbiter_if.sv - producer, register-file write and hazard signals of the writeback arbiter
interface regfile_writeback_arbiter_if #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              p0_valid;
  logic              p0_ready;
  logic [ADDR_W-1:0] p0_rd;
  logic [DATA_W-1:0] p0_data;
  logic              p1_valid;
  logic              p1_ready;
  logic [ADDR_W-1:0] p1_rd;
  logic [DATA_W-1:0] p1_data;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic [31:0]       pend_mask;
  logic [CNT_W-1:0]  fifo_count;

  modport master (
    output p0_valid, p0_rd, p0_data, p1_valid, p1_rd, p1_data,
    input  p0_ready, p1_ready, wb_we, wb_rd, wb_data, pend_mask, fifo_count
  );

  modport slave (
    input  p0_valid, p0_rd, p0_data, p1_valid, p1_rd, p1_data,
    output p0_ready, p1_ready, wb_we, wb_rd, wb_data, pend_mask, fifo_count
  );
endinterface

// File: rtl/regfile_writeback_arbiter.sv
// rtl/regfile_writeback_arbiter.sv - merges ALU and buffered load/muldiv results onto the register-file write port
// Also exports the pending-write mask consumed by the hazard unit.
module regfile_writeback_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3
) (
  input logic                       clk,
  input logic                       rst,
  regfile_writeback_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [SC_W-1:0]  SC_MAX   = SC_W'(STARVE_LIMIT);

  logic [ADDR_W-1:0] r_mem_rd   [FIFO_DEPTH];
  logic [DATA_W-1:0] r_mem_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [SC_W-1:0]   r_starve;
  logic              r_wb_we;
  logic [ADDR_W-1:0] r_wb_rd;
  logic [DATA_W-1:0] r_wb_data;

  logic              w_empty;
  logic              w_full;
  logic              w_force;
  logic              w_grant_p0;
  logic              w_grant_fifo;
  logic              w_push;
  logic [ADDR_W-1:0] w_sel_rd;
  logic [DATA_W-1:0] w_sel_data;
  logic [31:0]       w_pend;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);
  // A starved FIFO head pre-empts the ALU; otherwise the ALU always wins.
  assign w_force      = !w_empty && (r_starve == SC_MAX);
  assign w_grant_p0   = !w_force && bus.p0_valid;
  assign w_grant_fifo = !w_empty && (w_force || !bus.p0_valid);
  assign w_push       = bus.p1_valid && !w_full;

  assign w_sel_rd   = w_grant_fifo ? r_mem_rd[r_rd_ptr]   : bus.p0_rd;
  assign w_sel_data = w_grant_fifo ? r_mem_data[r_rd_ptr] : bus.p0_data;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_rd[r_wr_ptr]   <= bus.p1_rd;
      r_mem_data[r_wr_ptr] <= bus.p1_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_starve  <= '0;
      r_wb_we   <= 1'b0;
      r_wb_rd   <= '0;
      r_wb_data <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_grant_fifo) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_grant_fifo})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (w_grant_fifo || w_empty) begin
        r_starve <= '0;
      end else if (r_starve != SC_MAX) begin
        r_starve <= r_starve + 1'b1;
      end

      if (w_grant_p0 || w_grant_fifo) begin
        r_wb_we   <= (w_sel_rd != '0);
        r_wb_rd   <= w_sel_rd;
        r_wb_data <= w_sel_data;
      end else begin
        r_wb_we   <= 1'b0;
        r_wb_rd   <= '0;
        r_wb_data <= '0;
      end
    end
  end

  // Entry i is live when its distance from the read pointer is below the occupancy.
  always_comb begin : pend_calc
    logic [PTR_W-1:0] v_off;
    v_off  = '0;
    w_pend = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      v_off = PTR_W'(i) - r_rd_ptr;
      if ({1'b0, v_off} < r_count) begin
        w_pend[r_mem_rd[i]] = 1'b1;
      end
    end
    if (r_wb_we) begin
      w_pend[r_wb_rd] = 1'b1;
    end
    w_pend[0] = 1'b0;
  end

  assign bus.p0_ready   = !w_force;
  assign bus.p1_ready   = !w_full;
  assign bus.wb_we      = r_wb_we;
  assign bus.wb_rd      = r_wb_rd;
  assign bus.wb_data    = r_wb_data;
  assign bus.pend_mask  = w_pend;
  assign bus.fifo_count = r_count;
endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// tb/tb_regfile_writeback_arbiter.sv - scoreboard bench for regfile_writeback_arbiter
module tb_regfile_writeback_arbiter;
  logic clk;
  logic rst;

  int n_vec;
  int n_miss;
  logic [36:0] exp_q[$];

  regfile_writeback_arbiter_if #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(4)) bus ();

  regfile_writeback_arbiter #(
    .DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(4), .STARVE_LIMIT(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic expect_wb(input logic [4:0] rd, input logic [31:0] d);
    exp_q.push_back({rd, d});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every register-file write must match the next scoreboard entry.
  always @(negedge clk) begin : monitor
    logic [36:0] e;
    if (!rst && bus.wb_we) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL wb_unexpected: got rd=%0d data=0x%0h, required no write", bus.wb_rd, bus.wb_data);
      end else begin
        e = exp_q.pop_front();
        if ({bus.wb_rd, bus.wb_data} !== e) begin
          n_miss++;
          $display("FAIL wb_write: got rd=%0d data=0x%0h, required rd=%0d data=0x%0h",
                   bus.wb_rd, bus.wb_data, e[36:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst    = 1'b1;
    bus.p0_valid = 1'b0; bus.p0_rd = '0; bus.p0_data = '0;
    bus.p1_valid = 1'b0; bus.p1_rd = '0; bus.p1_data = '0;
    tick();
    tick();
    check("rst_count",    64'(bus.fifo_count), 64'd0);
    check("rst_we",       64'(bus.wb_we),      64'd0);
    check("rst_pend",     64'(bus.pend_mask),  64'd0);
    check("rst_p1_ready", 64'(bus.p1_ready),   64'd1);
    check("rst_p0_ready", 64'(bus.p0_ready),   64'd1);
    rst = 1'b0;
    tick();

    // p0 only
    bus.p0_valid = 1'b1; bus.p0_rd = 5'd5; bus.p0_data = 32'hDEADBEEF;
    expect_wb(5'd5, 32'hDEADBEEF);
    tick();
    bus.p0_valid = 1'b0;
    check("p0_we",   64'(bus.wb_we),     64'd1);
    check("p0_rd",   64'(bus.wb_rd),     64'd5);
    check("p0_data", 64'(bus.wb_data),   64'hDEADBEEF);
    check("p0_pend", 64'(bus.pend_mask), 64'h20);
    tick();
    check("p0_idle", 64'(bus.wb_we), 64'd0);

    // Fill FIFO with rd 1..4 while p0 keeps winning with x0 writes
    bus.p0_valid = 1'b1; bus.p0_rd = 5'd0; bus.p0_data = 32'h0;
    for (int i = 1; i <= 4; i++) begin
      bus.p1_valid = 1'b1; bus.p1_rd = 5'(i); bus.p1_data = 32'h100 + 32'(i);
      tick();
    end
    bus.p1_valid = 1'b0;
    check("fill_count",    64'(bus.fifo_count), 64'd4);
    check("fill_p1_ready", 64'(bus.p1_ready),   64'd0);
    check("fill_pend",     64'(bus.pend_mask),  64'h1E);

    // Starvation drain: each FIFO win follows three p0 wins
    bus.p0_rd = 5'd9;
    begin
      int j;
      j = 0;
      for (int k = 0; k < 13; k++) begin
        if (k % 4 == 0) begin
          check("starve_p0_ready_lo", 64'(bus.p0_ready), 64'd0);
          expect_wb(5'(k / 4 + 1), 32'h100 + 32'(k / 4 + 1));
        end else begin
          check("starve_p0_ready_hi", 64'(bus.p0_ready), 64'd1);
          bus.p0_data = 32'h900 + 32'(j);
          expect_wb(5'd9, 32'h900 + 32'(j));
          j++;
        end
        tick();
      end
    end
    bus.p0_valid = 1'b0;
    check("drain_count", 64'(bus.fifo_count), 64'd0);
    tick();

    // x0 writes from both ports
    bus.p0_valid = 1'b1; bus.p0_rd = 5'd0; bus.p0_data = 32'h1234;
    bus.p1_valid = 1'b1; bus.p1_rd = 5'd0; bus.p1_data = 32'h55;
    tick();
    bus.p0_valid = 1'b0; bus.p1_valid = 1'b0;
    check("x0_count1", 64'(bus.fifo_count), 64'd1);
    check("x0_pend",   64'(bus.pend_mask),  64'd0);
    check("x0_we1",    64'(bus.wb_we),      64'd0);
    tick();
    check("x0_count0", 64'(bus.fifo_count), 64'd0);
    check("x0_we2",    64'(bus.wb_we),      64'd0);
    tick();

    // Two entries buffered, then simultaneous push and pop
    bus.p0_valid = 1'b1; bus.p0_rd = 5'd0; bus.p0_data = 32'h0;
    bus.p1_valid = 1'b1; bus.p1_rd = 5'd11; bus.p1_data = 32'hB11;
    tick();
    bus.p1_rd = 5'd12; bus.p1_data = 32'hB12;
    tick();
    bus.p0_valid = 1'b0;
    check("pp_count_start", 64'(bus.fifo_count), 64'd2);
    expect_wb(5'd11, 32'hB11);
    expect_wb(5'd12, 32'hB12);
    for (int i = 0; i < 4; i++) begin
      bus.p1_valid = 1'b1; bus.p1_rd = 5'd7; bus.p1_data = 32'h700 + 32'(i);
      expect_wb(5'd7, 32'h700 + 32'(i));
      tick();
      check("pp_count",    64'(bus.fifo_count), 64'd2);
      check("pp_p1_ready", 64'(bus.p1_ready),   64'd1);
    end
    bus.p1_valid = 1'b0;
    tick();
    tick();
    check("pp_count_end", 64'(bus.fifo_count), 64'd0);
    tick();

    // Mid-stream reset with 3 buffered entries and a write in the output stage
    bus.p0_valid = 1'b1; bus.p0_rd = 5'd3;
    for (int i = 0; i < 3; i++) begin
      bus.p0_data = 32'h300 + 32'(i);
      bus.p1_valid = 1'b1; bus.p1_rd = 5'(20 + i); bus.p1_data = 32'h200 + 32'(i);
      if (i < 2) expect_wb(5'd3, 32'h300 + 32'(i));
      tick();
    end
    check("pre_rst_count", 64'(bus.fifo_count), 64'd3);
    check("pre_rst_we",    64'(bus.wb_we),      64'd1);
    check("pre_rst_pend",  64'(bus.pend_mask),  64'h0070_0008);
    rst = 1'b1;
    bus.p0_valid = 1'b0; bus.p1_valid = 1'b0;
    #1;
    check("mid_rst_count",    64'(bus.fifo_count), 64'd0);
    check("mid_rst_we",       64'(bus.wb_we),      64'd0);
    check("mid_rst_pend",     64'(bus.pend_mask),  64'd0);
    check("mid_rst_p1_ready", 64'(bus.p1_ready),   64'd1);
    check("mid_rst_p0_ready", 64'(bus.p0_ready),   64'd1);
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("post_rst_we", 64'(bus.wb_we), 64'd0);
    check("sb_drained",  64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
